// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Takes packed BCD words from the encoder array and drives a time-multiplexed
//   common-anode seven-segment display. A one-deep pending buffer holds the
//   next word. That word is copied into the display register only when the scan
//   wraps back to digit 0, so a single frame never mixes old and new digits.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   bcd_in       packed BCD word, digit 0 in bits [3:0]
//   in_valid     bcd_in is valid this cycle
//   in_ready     pending buffer empty (registered, no path from in_valid)
//   AN           digit enables, active low (one-hot-low or all high)
//   SEG          segments {g,f,e,d,c,b,a}, active low
//   DP           decimal point, active low, held off
//   frame_start  one-cycle pulse when the digit index wraps to 0
module bcd_display_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles show a dash. They still count as nonzero, so they
  // stop leading-zero blanking.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     disp_q, disp_d;
  logic [WORD_W-1:0]     pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  fs_q, fs_d;

  logic                  tick;
  logic                  wrap;
  logic [NUM_DIGITS:0]   upper_zero;
  logic [3:0]            nib;
  logic                  blank;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      fs_q        <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

  always_comb begin
    tick = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    // A swap needs a full buffer and an accept needs an empty one, so these
    // two branches can never fire in the same cycle.
    if (wrap && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (in_valid && !pend_full_q) begin
      pend_d      = bcd_in;
      pend_full_d = 1'b1;
    end

    fs_d = wrap;

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    upper_zero[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp_q[i*4 +: 4] == 4'd0);
    end

    // The decode uses the current idx/disp, so AN/SEG lag them by one cycle.
    nib   = '0;
    blank = 1'b0;
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib   = disp_q[i*4 +: 4];
        blank = (BLANK_LEADING != 0) && (i != 0) && upper_zero[i];
        if (!blank) begin
          an_d[i] = 1'b0;
        end
      end
    end
    seg_d = blank ? SEG_BLANK : seg_decode(nib);
  end

  assign in_ready    = !pend_full_q;
  assign AN          = an_q;
  assign SEG         = seg_q;
  assign DP          = 1'b1;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int ND = 8;
  localparam int RD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   bcd_in, bcd_nb;
  logic          in_valid, iv_nb;
  logic          in_ready, rdy_nb;
  logic [ND-1:0] AN, AN_nb;
  logic [6:0]    SEG, SEG_nb;
  logic          DP, DP_nb;
  logic          frame_start, fs_nb;

  int checks   = 0;
  int failures = 0;

  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut (
    .clock(clock), .reset(reset), .bcd_in(bcd_in), .in_valid(in_valid),
    .in_ready(in_ready), .AN(AN), .SEG(SEG), .DP(DP), .frame_start(frame_start)
  );

  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_nb (
    .clock(clock), .reset(reset), .bcd_in(bcd_nb), .in_valid(iv_nb),
    .in_ready(rdy_nb), .AN(AN_nb), .SEG(SEG_nb), .DP(DP_nb), .frame_start(fs_nb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic [6:0]  seg [8];
    logic [7:0]  shown;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Idle display after reset release: only digit 0 ("0") on the blanking
  // instance, all digits "0" on the non-blanking instance.
  task automatic idle_check(input int n);
    for (int j = 1; j <= n; j++) begin
      int d;
      logic [7:0] exp_an;
      step();
      d = ((j - 1) / 4) % 8;
      chk("idle_an", AN, (d == 0) ? 8'hFE : 8'hFF);
      chk("idle_seg", SEG, (d == 0) ? 7'h40 : 7'h7F);
      chk("idle_fs", frame_start, (j % 32) == 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_dp", DP, 1);
      exp_an = ~(8'd1 << d);
      chk("noblank_an", AN_nb, exp_an);
      chk("noblank_seg", SEG_nb, 7'h40);
    end
  endtask

  // Call with the bench sitting at the edge where frame_start rose;
  // iteration j checks the outputs after edge W+j.
  task automatic check_frame(input int vi, input int first);
    for (int j = first; j <= 32; j++) begin
      int d;
      logic [7:0] exp_an;
      step();
      d = (j - 1) / 4;
      exp_an = vecs[vi].shown[d] ? ~(8'd1 << d) : 8'hFF;
      chk("frame_an", AN, exp_an);
      chk("frame_seg", SEG, vecs[vi].seg[d]);
      chk("frame_fs", frame_start, j == 32);
    end
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
    chk("wait_frame_start", {31'b0, ok}, 1);
  endtask

  task automatic load(input logic [31:0] w);
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    bcd_in   = w;
    step();
    in_valid = 1'b0;
    chk("ready_after_accept", in_ready, 0);
  endtask

  initial begin
    vecs[0].word = 32'h0000_1234;
    vecs[0].seg  = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[0].shown = 8'b0000_1111;
    vecs[1].word = 32'h0000_A050;
    vecs[1].seg  = '{7'h40, 7'h12, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[1].shown = 8'b0000_1111;
    vecs[2].word = 32'h9999_9999;
    vecs[2].seg  = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
    vecs[2].shown = 8'b1111_1111;
    vecs[3].word = 32'h0000_0000;
    vecs[3].seg  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[3].shown = 8'b0000_0001;
    vecs[4].word = 32'h8000_0001;
    vecs[4].seg  = '{7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
    vecs[4].shown = 8'b1111_1111;
    vecs[5].word = 32'h0F00_000C;
    vecs[5].seg  = '{7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h7F};
    vecs[5].shown = 8'b0111_1111;

    reset    = 1'b1;
    in_valid = 1'b0;
    bcd_in   = '0;
    iv_nb    = 1'b0;
    bcd_nb   = '0;

    // Reset values, before any clock edge.
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_dp", DP, 1);
    chk("rst_fs", frame_start, 0);
    step();
    step();
    chk("rst_an_clocked", AN, 8'hFF);
    chk("rst_an_nb", AN_nb, 8'hFF);
    reset = 1'b0;

    idle_check(64);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].word);
      wait_fs();
      chk("ready_after_swap", in_ready, 1);
      check_frame(v, 1);
    end

    // Second word held on in_valid while the first is pending.
    in_valid = 1'b1;
    bcd_in   = 32'h0000_1234;
    step();
    chk("b2b_ready_low", in_ready, 0);
    bcd_in = 32'h9999_9999;
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        step();
        if (frame_start) begin
          ok = 1;
          break;
        end
        chk("b2b_ready_held_low", in_ready, 0);
      end
      chk("b2b_wait_frame_start", {31'b0, ok}, 1);
    end
    chk("b2b_ready_after_swap", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_second_accepted", in_ready, 0);
    chk("b2b_d0_an", AN, 8'hFE);
    chk("b2b_d0_seg", SEG, 7'h19);
    check_frame(0, 2);
    chk("b2b_ready_after_2nd_swap", in_ready, 1);
    check_frame(2, 1);

    // Reset with the buffer full while digit 5 is on.
    load(32'h5555_5555);
    for (int k = 0; k < 20; k++) step();
    chk("pre_rst_an_d5", AN, 8'hDF);
    chk("pre_rst_seg_d5", SEG, 7'h10);
    chk("pre_rst_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_an", AN, 8'hFF);
    chk("async_rst_seg", SEG, 7'h7F);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_fs", frame_start, 0);
    step();
    step();
    reset = 1'b0;
    idle_check(64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the BCD encoder array: accepts one packed BCD word per transfer and drives a time-multiplexed common-anode seven-segment display. A one-deep pending buffer decouples the encoder's `done` timing from the scan. New values are swapped in only at a frame boundary, so a frame never mixes old and new digits. Provides leading-zero blanking, an invalid-nibble indicator, and a frame-start strobe for the timing logic.

## Interface

- NUM_DIGITS, 8, number of display digits; BCD word is 4*NUM_DIGITS bits, digit 0 = bits [3:0] = least significant.
- REFRESH_DIV, 100000, clock cycles each digit is enabled; must be ≥2.
- BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits.

- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bcd_in  in  4*NUM_DIGITS  packed BCD word from encoder.
- in_valid  in  1  bcd_in valid this cycle.
- in_ready  out  1  pending buffer empty; transfer occurs when in_valid && in_ready at a rising edge.
- AN  out  NUM_DIGITS  digit enables, active low, one-hot-low or all-high.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active low.
- DP  out  1  decimal point, active low; held 1 (off).
- frame_start  out  1  one-cycle pulse when digit index wraps to 0.

## Operation

- State: prescaler `div_cnt` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1), `disp_reg`, `pend_reg`, `pend_full`.
- `div_cnt` increments every cycle; at REFRESH_DIV-1 it returns to 0 and asserts internal `tick`.
- On `tick`: `idx` <= `idx`+1, wrapping NUM_DIGITS-1 -> 0.
- Wrap event (`tick` && `idx`==NUM_DIGITS-1):
  - frame_start <= 1 for one cycle.
  - If `pend_full`: `disp_reg` <= `pend_reg`, `pend_full` <= 0.
- in_ready = !`pend_full` (registered state, no combinational path from in_valid).
- Accept (in_valid && in_ready): `pend_reg` <= bcd_in, `pend_full` <= 1.
- Pending full: in_ready = 0 and in_valid is ignored. A second word is never overwritten and never lost once accepted.
- Accept and wrap in the same cycle cannot occur, because wrap transfers only when full and accept requires empty. If the buffer is empty at wrap, `disp_reg` is unchanged.
- Registered output decode each cycle from `idx` and `disp_reg`:
  - AN = all ones except bit `idx` = 0, unless the digit is blanked, in which case AN = all ones.
  - Blanked: BLANK_LEADING=1 && `idx`≠0 && nibbles `idx`..NUM_DIGITS-1 all zero. SEG = 1111111 when blanked.
  - Nibble 0-9 SEG: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
  - Nibble 10-15: dash, SEG = 0111111. Nonzero for blanking purposes.
  - DP = 1 always.

## Timing

- Reset values (asynchronous, immediate): `div_cnt`=0, `idx`=0, `disp_reg`=0, `pend_reg`=0, `pend_full`=0.
- Output reset values: in_ready=1, AN=all ones, SEG=1111111, DP=1, frame_start=0.
- First rising edge after reset release: AN=11111110, SEG=1000000 (digit 0 shows "0").
- Each digit is enabled for exactly REFRESH_DIV cycles. One frame = NUM_DIGITS*REFRESH_DIV cycles.
- frame_start period = NUM_DIGITS*REFRESH_DIV. First pulse occurs NUM_DIGITS*REFRESH_DIV cycles after reset release.
- AN/SEG lag `idx`/`disp_reg` by one cycle. A transfer at a wrap is visible on digit 0 in the cycle after frame_start rises.
- Accept-to-display latency: between 2 and NUM_DIGITS*REFRESH_DIV+1 cycles.
- in_ready returns high in the cycle after the wrap that emptied the buffer.
- Reset asserted mid-frame or with the buffer full: all state is cleared, and the pending word is discarded.

## Test plan

(Sim parameters: NUM_DIGITS=8, REFRESH_DIV=4.)
- Reset, then idle 64 cycles -> AN cycles 11111110 only (digits 1-7 blanked, AN=11111111, SEG=1111111); frame_start pulses every 32 cycles; in_ready=1.
- Accept 0x00001234 mid-frame -> in_ready drops next cycle; after next frame_start, digits 0..3 show 4,3,2,1 (SEG 0011001, 0110000, 0100100, 1111001); digits 4-7 blanked; in_ready=1 again.
- Accept 0x00001234, then hold in_valid with 0x99999999 -> second word accepted only after the wrap; display shows 1234 for one full frame, then 99999999.
- Word 0x0000A050 with BLANK_LEADING=1 -> digit 0 "0", digit 1 "5", digit 2 "0" (not blanked), digit 3 dash 0111111, digits 4-7 blanked.
- BLANK_LEADING=0, word 0 -> all 8 digits enabled in turn with SEG=1000000.
- Assert reset while buffer full and mid-digit 5 -> AN=11111111, in_ready=1 immediately; after release, display shows "0" and the old word never appears.
